// File: rtl/reduce_pipe_pkg.sv
// Shared types and constants for the two-stage reduction pipeline.
// red_t carries one channel's OR / AND / XOR reductions between stages.
package reduce_pipe_pkg;

  typedef struct packed {
    logic x;
    logic a;
    logic o;
  } red_t;

  localparam int PO_NAND   = 0;
  localparam int PO_OR     = 1;
  localparam int PO_PAR    = 2;
  localparam int PO_PER_CH = 3;

  function automatic logic [PO_PER_CH-1:0] combine(input red_t r);
    logic [PO_PER_CH-1:0] v;
    v          = '0;
    v[PO_NAND] = ~(r.o & r.a);
    v[PO_OR]   = r.o | r.a;
    v[PO_PAR]  = r.x;
    return v;
  endfunction

endpackage

// File: rtl/reduce_lane.sv
// One channel's stage-1 reduction: OR / AND / XOR of a word, held in a
// red_t register that only loads when a valid word is accepted.
module reduce_lane
  import reduce_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  output logic [2:0]       o_red
);

  if (WIDTH < 2) begin : g_badWidth
    $error("reduce_lane: WIDTH must be at least 2");
  end

  red_t r_red;
  red_t w_next;

  always_comb begin
    w_next   = '0;
    w_next.o = |i_word;
    w_next.a = &i_word;
    w_next.x = ^i_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_red <= '0;
    end else if (i_load) begin
      r_red <= w_next;
    end
  end

  assign o_red = r_red;

endmodule

// File: rtl/reduce_pipe.sv
// Two-stage handshaked reduction pipeline: per-channel reductions (stage 1),
// then NAND / OR / parity combine (stage 2), plus a delivered-result counter.
module reduce_pipe
  import reduce_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic                     CK,
  input  logic                     RN,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*WIDTH-1:0]     pi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*PO_PER_CH-1:0] po,
  output logic [CNT_W-1:0]         out_cnt
);

  if (CNT_W < 1) begin : g_badCntW
    $error("reduce_pipe: CNT_W must be at least 1");
  end

  logic                     r_s1Valid;
  logic                     r_s2Valid;
  logic [NCH*PO_PER_CH-1:0] r_po;
  logic [CNT_W-1:0]         r_outCnt;

  logic                     w_adv1;
  logic                     w_adv2;
  logic                     w_load1;
  logic [NCH*PO_PER_CH-1:0] w_comb;

  // A stage may move whenever the stage after it is empty or moving too.
  assign w_adv2  = ~r_s2Valid | out_ready;
  assign w_adv1  = ~r_s1Valid | w_adv2;
  assign w_load1 = w_adv1 & in_valid;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    logic [2:0] w_red;

    reduce_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .i_clk  (CK),
      .i_rst_n(RN),
      .i_load (w_load1),
      .i_word (pi[c*WIDTH +: WIDTH]),
      .o_red  (w_red)
    );

    assign w_comb[c*PO_PER_CH +: PO_PER_CH] = combine(red_t'(w_red));
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
      r_po      <= '0;
      r_outCnt  <= '0;
    end else begin
      if (w_adv1) begin
        r_s1Valid <= in_valid;
      end
      if (w_adv2) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_po <= w_comb;
        end
      end
      if (r_s2Valid && out_ready) begin
        r_outCnt <= r_outCnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_s2Valid;
  assign po        = r_po;
  assign out_cnt   = r_outCnt;

endmodule

// File: tb/tb_reduce_pipe.sv
// Directed bench for reduce_pipe: a queue scoreboard checks every delivered
// word, while directed steps check reset, latency, stall and counter wrap.
module tb_reduce_pipe;

  logic        CK;
  logic        RN;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pi;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  po;
  logic [15:0] out_cnt;

  logic        rnW;
  logic        inValidW;
  logic        inReadyW;
  logic [15:0] piW;
  logic        outValidW;
  logic        outReadyW;
  logic [5:0]  poW;
  logic [2:0]  outCntW;

  int          checks;
  int          failures;
  int          outCount;
  int          outBefore;
  logic [15:0] cntBefore;
  logic [15:0] words [4];
  logic [5:0]  expQ [$];
  logic [5:0]  expHead;

  reduce_pipe #(.WIDTH(8), .NCH(2), .CNT_W(16)) u_dut (
    .CK       (CK),
    .RN       (RN),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pi       (pi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .po       (po),
    .out_cnt  (out_cnt)
  );

  reduce_pipe #(.WIDTH(8), .NCH(2), .CNT_W(3)) u_wrap (
    .CK       (CK),
    .RN       (rnW),
    .in_valid (inValidW),
    .in_ready (inReadyW),
    .pi       (piW),
    .out_valid(outValidW),
    .out_ready(outReadyW),
    .po       (poW),
    .out_cnt  (outCntW)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Reference: channel c gives {parity, or|and, ~(or&and)} at bits 3c+2..3c.
  function automatic logic [5:0] expPo(input logic [15:0] d);
    logic [5:0] r;
    logic [7:0] w;
    logic       o;
    logic       a;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      w = d[c*8 +: 8];
      o = |w;
      a = &w;
      r[c*3]   = ~(o & a);
      r[c*3+1] = o | a;
      r[c*3+2] = ^w;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
    in_valid  = v;
    pi        = d;
    out_ready = r;
    @(posedge CK);
    #1;
  endtask

  task automatic applyWrap(input logic v, input logic r);
    inValidW  = v;
    piW       = 16'($urandom);
    outReadyW = r;
    @(posedge CK);
    #1;
  endtask

  // Scoreboard monitor: inputs only change just after a rising edge, so the
  // falling edge sees the handshakes that the next rising edge will act on.
  always @(negedge CK) begin
    if (RN) begin
      if (out_valid && out_ready) begin
        checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          expHead = expQ.pop_front();
          checkOutput("sb_po", 32'(po), 32'(expHead));
          outCount++;
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(expPo(pi));
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    outCount  = 0;
    RN        = 1'b0;
    rnW       = 1'b0;
    in_valid  = 1'b0;
    pi        = '0;
    out_ready = 1'b0;
    inValidW  = 1'b0;
    piW       = '0;
    outReadyW = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    RN  = 1'b1;
    rnW = 1'b1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_cnt", 32'(out_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] reset with traffic in flight");
    repeat (3) applyStimulus(1'b1, 16'($urandom), 1'b1);
    checkOutput("pre_rst_cnt", 32'(out_cnt), 32'd1);
    RN = 1'b0;
    expQ.delete();
    #2;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_po", 32'(po), 32'd0);
    checkOutput("midrst_out_cnt", 32'(out_cnt), 32'd0);
    @(posedge CK);
    #1;
    checkOutput("midrst_hold_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    RN       = 1'b1;
    checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("postrst_no_output", 32'(out_valid), 32'd0);

    $display("[TB] latency and truth table");
    applyStimulus(1'b1, 16'hFF00, 1'b1);
    checkOutput("lat_edge1_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("lat_edge2_valid", 32'(out_valid), 32'd1);
    checkOutput("truth_ff00", 32'(po), 32'h11);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("lat_pulse_end", 32'(out_valid), 32'd0);
    checkOutput("cnt_after_t2", 32'(out_cnt), 32'd1);

    applyStimulus(1'b1, 16'h0001, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("truth_0001", 32'(po), 32'h0F);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("cnt_after_t3", 32'(out_cnt), 32'd2);

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    applyStimulus(1'b1, words[0], 1'b0);
    checkOutput("bp_ready_1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, words[1], 1'b0);
    checkOutput("bp_ready_full", 32'(in_ready), 32'd0);
    checkOutput("bp_valid_full", 32'(out_valid), 32'd1);
    checkOutput("bp_po_full", 32'(po), 32'(expPo(words[0])));
    applyStimulus(1'b1, words[2], 1'b0);
    checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_stall_po", 32'(po), 32'(expPo(words[0])));
    checkOutput("bp_stall_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, words[2], 1'b1);
    applyStimulus(1'b1, words[3], 1'b1);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("bp_cnt", 32'(out_cnt), 32'd6);
    checkOutput("bp_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] full throughput");
    outBefore = outCount;
    cntBefore = out_cnt;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'b1);
      checkOutput("tp_in_ready", 32'(in_ready), 32'd1);
    end
    repeat (2) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("tp_outputs", 32'(outCount - outBefore), 32'd20);
    checkOutput("tp_cnt", 32'(16'(out_cnt - cntBefore)), 32'd20);
    checkOutput("tp_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] counter wrap and reset flush on CNT_W=3 instance");
    repeat (9) applyWrap(1'b1, 1'b1);
    repeat (2) applyWrap(1'b0, 1'b1);
    checkOutput("wrap_cnt", 32'(outCntW), 32'd1);
    repeat (2) applyWrap(1'b1, 1'b0);
    checkOutput("wrap_full_valid", 32'(outValidW), 32'd1);
    checkOutput("wrap_full_ready", 32'(inReadyW), 32'd0);
    rnW = 1'b0;
    #2;
    checkOutput("wrap_rst_valid", 32'(outValidW), 32'd0);
    checkOutput("wrap_rst_po", 32'(poW), 32'd0);
    checkOutput("wrap_rst_cnt", 32'(outCntW), 32'd0);
    checkOutput("wrap_rst_ready", 32'(inReadyW), 32'd1);
    @(posedge CK);
    #1;
    inValidW  = 1'b0;
    outReadyW = 1'b1;
    rnW       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyWrap(1'b0, 1'b1);
      checkOutput("wrap_flushed", 32'(outValidW), 32'd0);
    end
    checkOutput("wrap_cnt_after", 32'(outCntW), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
